// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational 16-bit ALU: accepts ops, sequences one or two ALU passes, returns a registered response.
// Optional feature macro: ALU_ISSUE_ABSDIFF_EN enables opcode 8 (ABSDIFF) and the PASS2 state.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_code,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic [3:0]  alu_select,
    output logic [15:0] alu_data1,
    output logic [15:0] alu_data2,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_zero,
    output logic        res_branch,
    output logic        res_illegal,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer occurs on a rising edge where valid and ready are both high;
    // a producer holds valid and its payload stable until that edge.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;

    localparam logic [3:0] OP_AND     = 4'd0;
    localparam logic [3:0] OP_OR      = 4'd1;
    localparam logic [3:0] OP_ADD     = 4'd2;
    localparam logic [3:0] OP_BEQ     = 4'd4;
    localparam logic [3:0] OP_BNE     = 4'd5;
    localparam logic [3:0] OP_SLT     = 4'd6;
    localparam logic [3:0] OP_NEG     = 4'd7;
    localparam logic [3:0] OP_ABSDIFF = 4'd8;

    state_t      state;
    logic [3:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] diff;
    logic        ovf;
    logic        lt;

    function automatic logic is_legal(input logic [3:0] code);
`ifdef ALU_ISSUE_ABSDIFF_EN
        return code <= OP_ABSDIFF;
`else
        return code <= OP_NEG;
`endif
    endfunction

    function automatic logic [3:0] sel_for(input logic [3:0] code);
        case (code)
            OP_AND:  return SEL_AND;
            OP_OR:   return SEL_OR;
            OP_ADD:  return SEL_ADD;
            default: return SEL_SUB;
        endcase
    endfunction

    // Signed a<b from the latched operands, independent of which pass the ALU is on.
    always_comb begin
        diff = a_q - b_q;
        ovf  = (a_q[15] != b_q[15]) && (diff[15] != a_q[15]);
        lt   = diff[15] ^ ovf;
    end

    assign op_ready  = (state == IDLE) && !reset;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            alu_select  <= SEL_AND;
            alu_data1   <= '0;
            alu_data2   <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_zero    <= 1'b0;
            res_branch  <= 1'b0;
            res_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        op_q <= op_code;
                        a_q  <= op_a;
                        b_q  <= op_b;
                        if (is_legal(op_code)) begin
                            alu_select <= sel_for(op_code);
                            alu_data1  <= (op_code == OP_NEG) ? 16'h0000 : op_a;
                            alu_data2  <= (op_code == OP_NEG) ? op_a : op_b;
                            state      <= PASS1;
                        end else begin
                            res_valid   <= 1'b1;
                            res_illegal <= 1'b1;
                            res_data    <= '0;
                            res_zero    <= 1'b1;
                            res_branch  <= 1'b0;
                            state       <= HOLD;
                        end
                    end
                end
                PASS1: begin
`ifdef ALU_ISSUE_ABSDIFF_EN
                    if (op_q == OP_ABSDIFF && lt) begin
                        alu_data1 <= b_q;
                        alu_data2 <= a_q;
                        state     <= PASS2;
                    end else
`endif
                    begin
                        res_valid   <= 1'b1;
                        res_illegal <= 1'b0;
                        res_data    <= (op_q == OP_SLT) ? {15'b0, lt} : alu_result;
                        res_zero    <= (op_q == OP_SLT) ? !lt : alu_zero;
                        res_branch  <= (op_q == OP_BEQ) ? alu_zero :
                                       (op_q == OP_BNE) ? !alu_zero : 1'b0;
                        state       <= HOLD;
                    end
                end
`ifdef ALU_ISSUE_ABSDIFF_EN
                PASS2: begin
                    res_valid   <= 1'b1;
                    res_illegal <= 1'b0;
                    res_data    <= alu_result;
                    res_zero    <= alu_zero;
                    res_branch  <= 1'b0;
                    state       <= HOLD;
                end
`endif
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: vector table for single ops plus hand sequences for reset, hold and PASS2 timing.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_code;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  alu_select;
    logic [15:0] alu_data1;
    logic [15:0] alu_data2;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_zero;
    logic        res_branch;
    logic        res_illegal;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    // Reference combinational ALU.
    always_comb begin
        case (alu_select)
            4'b0000: alu_result = alu_data1 & alu_data2;
            4'b0001: alu_result = alu_data1 | alu_data2;
            4'b0010: alu_result = alu_data1 + alu_data2;
            4'b0110: alu_result = alu_data1 - alu_data2;
            default: alu_result = 16'h0000;
        endcase
        alu_zero = (alu_result == 16'h0000);
    end

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_a(op_a), .op_b(op_b),
        .alu_select(alu_select), .alu_data1(alu_data1), .alu_data2(alu_data2),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_zero(res_zero),
        .res_branch(res_branch), .res_illegal(res_illegal),
        .dbg_state(dbg_state)
    );

    typedef struct {
        logic [3:0]  code;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] data;
        logic        zero;
        logic        branch;
        logic        illegal;
        logic [3:0]  sel;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] code, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] data, input logic zero, input logic branch,
                           input logic illegal, input logic [3:0] sel, input int lat);
        vec_t v;
        v.code = code; v.a = a; v.b = b; v.data = data; v.zero = zero;
        v.branch = branch; v.illegal = illegal; v.sel = sel; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Presents one op at a negedge and returns just after its accept edge.
    task automatic send(input logic [3:0] code, input logic [15:0] a, input logic [15:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!op_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("op_ready_before_send", {31'b0, op_ready}, 32'd1);
        op_valid = 1'b1;
        op_code  = code;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    // Counts cycles after the accept edge until res_valid; lat stays 0 on timeout.
    task automatic wait_res(output int lat, output logic [3:0] sel_c1);
        lat    = 0;
        sel_c1 = 4'hx;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) sel_c1 = alu_select;
            if (res_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic take_res();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check("res_valid_after_take", {31'b0, res_valid}, 32'd0);
    endtask

    initial begin
        int          lat;
        logic [3:0]  sel1;
        logic [15:0] exp_data;
        int          seen;

        reset     = 1'b1;
        op_valid  = 1'b0;
        op_code   = 4'h0;
        op_a      = 16'h0;
        op_b      = 16'h0;
        res_ready = 1'b0;

        //            code   a        b        data     z     br    ill   sel      lat
        add_vec(4'd2, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b0, 4'b0010, 2);
        add_vec(4'd0, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 4'b0000, 2);
        add_vec(4'd1, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0, 1'b0, 4'b0001, 2);
        add_vec(4'd3, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 4'b0110, 2);
        add_vec(4'd3, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'b0110, 2);
        add_vec(4'd4, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0, 4'b0110, 2);
        add_vec(4'd5, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 4'b0110, 2);
        add_vec(4'd5, 16'h1234, 16'h1235, 16'hFFFF, 1'b0, 1'b1, 1'b0, 4'b0110, 2);
        add_vec(4'd4, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'b0110, 2);
        add_vec(4'd6, 16'h8000, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 4'b0110, 2);
        add_vec(4'd6, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 4'b0110, 2);
        add_vec(4'd6, 16'h0001, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0, 4'b0110, 2);
        add_vec(4'd7, 16'h0001, 16'h5555, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'b0110, 2);
        add_vec(4'd7, 16'h0000, 16'h5555, 16'h0000, 1'b1, 1'b0, 1'b0, 4'b0110, 2);
        add_vec(4'hC, 16'h1111, 16'h2222, 16'h0000, 1'b1, 1'b0, 1'b1, 4'b0000, 1);
        add_vec(4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 4'b0000, 1);
`ifdef ALU_ISSUE_ABSDIFF_EN
        add_vec(4'd8, 16'h0003, 16'h000A, 16'h0007, 1'b0, 1'b0, 1'b0, 4'b0110, 3);
        add_vec(4'd8, 16'h000A, 16'h0003, 16'h0007, 1'b0, 1'b0, 1'b0, 4'b0110, 2);
        add_vec(4'd8, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 4'b0110, 2);
`else
        add_vec(4'd8, 16'h0003, 16'h000A, 16'h0000, 1'b1, 1'b0, 1'b1, 4'b0000, 1);
`endif

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_op_ready", {31'b0, op_ready}, 32'd0);
        check("reset_res_valid", {31'b0, res_valid}, 32'd0);
        check("reset_alu_select", {28'b0, alu_select}, 32'd0);
        check("reset_alu_data1", {16'b0, alu_data1}, 32'd0);
        check("reset_alu_data2", {16'b0, alu_data2}, 32'd0);
        check("reset_res_flags", {28'b0, res_zero, res_branch, res_illegal, 1'b0}, 32'd0);
        check("reset_res_data", {16'b0, res_data}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_op_ready", {31'b0, op_ready}, 32'd1);
        check("idle_state", {30'b0, dbg_state}, 32'd0);

        // Table-driven single ops.
        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].code, vecs[i].a, vecs[i].b);
            exp_q.push_back(vecs[i].data);
            wait_res(lat, sel1);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            exp_data = exp_q.pop_front();
            check($sformatf("v%0d_res_data", i), {16'b0, res_data}, {16'b0, exp_data});
            check($sformatf("v%0d_res_zero", i), {31'b0, res_zero}, {31'b0, vecs[i].zero});
            check($sformatf("v%0d_res_branch", i), {31'b0, res_branch}, {31'b0, vecs[i].branch});
            check($sformatf("v%0d_res_illegal", i), {31'b0, res_illegal}, {31'b0, vecs[i].illegal});
            if (!vecs[i].illegal)
                check($sformatf("v%0d_alu_select", i), {28'b0, sel1}, {28'b0, vecs[i].sel});
            take_res();
        end

        // ALU drive registers keep their values after the transfer.
        send(4'd2, 16'h7FFF, 16'h0001);
        wait_res(lat, sel1);
        take_res();
        check("retain_alu_data1", {16'b0, alu_data1}, 32'h7FFF);
        check("retain_alu_data2", {16'b0, alu_data2}, 32'h0001);
        check("retain_alu_select", {28'b0, alu_select}, 32'h2);

`ifdef ALU_ISSUE_ABSDIFF_EN
        // ABSDIFF with a<b: PASS2 swaps the operands.
        send(4'd8, 16'h0003, 16'h000A);
        @(negedge clk);
        check("absd_c1_data1", {16'b0, alu_data1}, 32'h0003);
        check("absd_c1_data2", {16'b0, alu_data2}, 32'h000A);
        @(negedge clk);
        check("absd_c2_data1", {16'b0, alu_data1}, 32'h000A);
        check("absd_c2_data2", {16'b0, alu_data2}, 32'h0003);
        check("absd_c2_res_valid", {31'b0, res_valid}, 32'd0);
        @(negedge clk);
        check("absd_c3_res_valid", {31'b0, res_valid}, 32'd1);
        check("absd_c3_res_data", {16'b0, res_data}, 32'h0007);
        take_res();
`endif

        // Illegal op held with res_ready low.
        send(4'hC, 16'hABCD, 16'h1234);
        @(negedge clk);
        check("ill_c1_res_valid", {31'b0, res_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("ill_hold%0d", k),
                  {12'b0, res_valid, res_illegal, res_zero, res_branch, op_ready, res_data},
                  {12'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000});
        end
        take_res();

        // Reset during PASS1 of SUB aborts with no response.
        send(4'd3, 16'h0009, 16'h0004);
        @(negedge clk);
        check("abort_in_pass1", {30'b0, dbg_state}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_res_valid", {31'b0, res_valid}, 32'd0);
        check("abort_op_ready_in_reset", {31'b0, op_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_op_ready_after", {31'b0, op_ready}, 32'd1);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        check("abort_no_response", seen, 0);

        // res_ready high before res_valid: single-cycle response, back to IDLE next cycle.
        res_ready = 1'b1;
        send(4'd1, 16'h0003, 16'h0300);
        @(negedge clk);
        check("early_c1_res_valid", {31'b0, res_valid}, 32'd0);
        @(negedge clk);
        check("early_c2_res_valid", {31'b0, res_valid}, 32'd1);
        check("early_c2_res_data", {16'b0, res_data}, 32'h0303);
        @(negedge clk);
        check("early_c3_res_valid", {31'b0, res_valid}, 32'd0);
        check("early_c3_op_ready", {31'b0, op_ready}, 32'd1);
        res_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential front end that owns the initiator side of the 16-bit ALU interface. It accepts instruction-level operations over a valid/ready handshake, drives the ALU's 4-bit select and two 16-bit operand inputs from registers, and captures the ALU's result and zero flag. It returns a registered result with branch and compare decisions over a second valid/ready handshake. It sits between decode/register-read and writeback/branch logic; the ALU itself stays purely combinational.

## Interface
- No parameters.
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- op_valid  in  1  request valid
- op_ready  out  1  high only in IDLE and not in reset
- op_code  in  4  operation, see Operation
- op_a  in  16  operand A
- op_b  in  16  operand B
- alu_select  out  4  registered ALU select: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB
- alu_data1  out  16  registered ALU operand 1
- alu_data2  out  16  registered ALU operand 2
- alu_result  in  16  combinational ALU result
- alu_zero  in  1  combinational ALU zero flag
- res_valid  out  1  response valid
- res_ready  in  1  consumer accepts response
- res_data  out  16  final result
- res_zero  out  1  zero/false flag
- res_branch  out  1  branch taken
- res_illegal  out  1  op_code not supported

## Operation
- States are IDLE, PASS1, PASS2 and HOLD.
- IDLE:
  - op_ready is 1.
  - On op_valid, latch op_code, op_a and op_b, load alu_select, alu_data1 and alu_data2, then go to PASS1.
  - For an illegal code, go straight to HOLD with res_illegal=1, res_data=0, res_zero=1 and res_branch=0.
- Opcodes, with the ALU drive for PASS1:
  - 0 AND: a & b
  - 1 OR: a | b
  - 2 ADD: a + b
  - 3 SUB: a − b
  - 4 BEQ: SUB a,b; res_branch = alu_zero
  - 5 BNE: SUB a,b; res_branch = ~alu_zero
  - 6 SLT: SUB a,b; res_data = {15'b0, lt}; res_zero = ~lt
  - 7 NEG: SUB with data1=0, data2=a
  - 8 ABSDIFF: SUB a,b; if lt, run PASS2 as SUB b,a
  - 9–15: illegal
- Signed less-than: lt = r[15] ^ ovf, where r = a−b mod 2^16 and ovf = (a[15]≠b[15]) & (r[15]≠a[15]).
- Result capture:
  - PASS1 captures alu_result and alu_zero at the end of the cycle.
  - For all ops except SLT, res_data = the last pass's alu_result and res_zero = the last pass's alu_zero.
  - res_branch = 0 except for BEQ and BNE.
- Arithmetic wraps modulo 2^16; no carry or overflow outputs.
- ABSDIFF: PASS1 goes to PASS2 if lt, otherwise to HOLD. PASS2 reloads the ALU drive with b,a and captures the final result.
- HOLD: res_valid=1. When res_ready is high, go to IDLE and drop res_valid. res_* outputs stay stable while res_valid is high and res_ready is low.
- After a transfer, ALU drive registers keep their last values; they are not cleared.

## Timing
- Reset values:
  - state IDLE
  - op_ready 0 while reset is high
  - alu_select 0000, alu_data1 0, alu_data2 0
  - res_valid 0, res_data 0, res_zero 0, res_branch 0, res_illegal 0
- Latency, with accept edge = cycle 0:
  - Single-pass op: ALU driven during cycle 1; res_valid rises at cycle 2.
  - ABSDIFF needing PASS2: res_valid rises at cycle 3.
  - Illegal op: res_valid rises at cycle 1.
- Throughput: one op per 3 cycles at best (accept, PASS, HOLD with res_ready=1, back to IDLE). No overlap; op_ready is 0 outside IDLE.
- res_ready may be high before res_valid; the transfer happens on the first HOLD cycle.
- Reset mid-operation aborts the op silently. The next cycle is IDLE with all outputs at reset values, and no response is emitted.
- op_valid is ignored outside IDLE; requests must be held until op_ready.

## Configuration
- ALU_ISSUE_ABSDIFF_EN:
  - Defined: opcode 8 (ABSDIFF) and the PASS2 state are implemented.
  - Undefined: opcode 8 is illegal (res_illegal=1, latency 1), PASS2 is absent, and the maximum latency is 2.

## Test plan
- Reset, then ADD a=0x7FFF, b=0x0001 → alu_select=0010 in cycle 1; at cycle 2 res_data=0x8000, res_zero=0, res_branch=0.
- BEQ a=b=0x1234 → res_data=0, res_zero=1, res_branch=1; BNE with the same operands → res_branch=0.
- SLT a=0x8000, b=0x0001 (overflow path) → res_data=0x0001, res_zero=0; SLT a=0x0005, b=0x0005 → res_data=0, res_zero=1.
- ABSDIFF a=0x0003, b=0x000A → PASS2 drives data1=0x000A, data2=0x0003; res_data=0x0007 at cycle 3. ABSDIFF a=0x000A, b=0x0003 → 0x0007 at cycle 2.
- Opcode 0xC → res_illegal=1, res_data=0 at cycle 1. Holding res_ready=0 for 5 cycles keeps outputs stable and op_ready=0.
- Assert reset during PASS1 of SUB → next cycle res_valid=0, op_ready=1 after reset deasserts, and no response appears.
